world_step_sequencer: RTL and testbench

//  Sequences one robot step per iteration against a single-port map RAM (1-cycle read latency).

---
 rtl/world_step_sequencer.sv | 266 ++++++++++++++++++++++++++
 tb/tb_world_step_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/world_step_sequencer.sv
// One robot step per iteration: read front/left/own map cells, drive the robot sensors,
// tick the robot, then apply its move/turn/remove decision to the position and the map.
module world_step_sequencer #(
    parameter int ROWS     = 10,
    parameter int COLS     = 20,
    parameter int ADDR_W   = 8,
    parameter int STEP_GAP = 4,
    parameter int RM_STEPS = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              load,
    input  logic [5:0]        init_row,
    input  logic [5:0]        init_column,
    input  logic [1:0]        init_orientation,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [2:0]        mem_wdata,
    input  logic [2:0]        mem_rdata,
    output logic              head,
    output logic              left,
    output logic              under,
    output logic              barrier,
    output logic              robot_clock,
    input  logic              front,
    input  logic              turn,
    input  logic              remove,
    output logic [5:0]        robot_row,
    output logic [5:0]        robot_column,
    output logic [1:0]        robot_orientation,
    output logic              busy,
    output logic              step_done
);

    localparam logic [1:0] OR_N = 2'b00;
    localparam logic [1:0] OR_S = 2'b01;
    localparam logic [1:0] OR_E = 2'b10;
    localparam logic [1:0] OR_W = 2'b11;

    localparam logic [2:0] CELL_WALL  = 3'd1;
    localparam logic [2:0] CELL_TRASH = 3'd2;
    localparam logic [2:0] CELL_DIRT  = 3'd7;

    localparam logic [5:0] ROW_MAX = 6'(ROWS);
    localparam logic [5:0] COL_MAX = 6'(COLS);

    localparam int GAP_W = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
    localparam int RM_W  = (RM_STEPS > 1) ? $clog2(RM_STEPS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDF,
        S_RDL,
        S_RDU,
        S_CAP,
        S_TICK,
        S_APPLY,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [RM_W-1:0]   rm_cnt_q, rm_cnt_d;
    logic [5:0]        row_q, row_d;
    logic [5:0]        col_q, col_d;
    logic [1:0]        ori_q, ori_d;
    logic [2:0]        front_data_q, front_data_d;
    logic [2:0]        left_data_q, left_data_d;
    logic              head_q, head_d;
    logic              left_q, left_d;
    logic              under_q, under_d;
    logic              barrier_q, barrier_d;
    logic              robot_clock_q, robot_clock_d;
    logic              step_done_q, step_done_d;

    logic [5:0]        fr_row, fr_col, lf_row, lf_col;
    logic              front_ok, left_ok;
    logic              rm_last;

    function automatic logic in_range(input logic [5:0] r, input logic [5:0] c);
        return (r >= 6'd1) && (r <= ROW_MAX) && (c >= 6'd1) && (c <= COL_MAX);
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [5:0] r, input logic [5:0] c);
        int a;
        a = int'(r) * COLS + int'(c);
        return ADDR_W'(a);
    endfunction

    function automatic logic [1:0] turn_left(input logic [1:0] o);
        logic [1:0] n;
        case (o)
            OR_N:    n = OR_W;
            OR_W:    n = OR_S;
            OR_S:    n = OR_E;
            default: n = OR_N;
        endcase
        return n;
    endfunction

    // Front and left-hand neighbour coordinates; row 0 wraps to 63 and reads as out of range.
    always_comb begin
        fr_row = row_q;
        fr_col = col_q;
        lf_row = row_q;
        lf_col = col_q;
        case (ori_q)
            OR_N: begin
                fr_row = row_q - 6'd1;
                lf_col = col_q - 6'd1;
            end
            OR_S: begin
                fr_row = row_q + 6'd1;
                lf_col = col_q + 6'd1;
            end
            OR_E: begin
                fr_col = col_q + 6'd1;
                lf_row = row_q - 6'd1;
            end
            default: begin
                fr_col = col_q - 6'd1;
                lf_row = row_q + 6'd1;
            end
        endcase
    end

    assign front_ok = in_range(fr_row, fr_col);
    assign left_ok  = in_range(lf_row, lf_col);
    assign rm_last  = (rm_cnt_q == RM_W'(RM_STEPS - 1));

    always_comb begin
        state_d       = state_q;
        gap_cnt_d     = gap_cnt_q;
        rm_cnt_d      = rm_cnt_q;
        row_d         = row_q;
        col_d         = col_q;
        ori_d         = ori_q;
        front_data_d  = front_data_q;
        left_data_d   = left_data_q;
        head_d        = head_q;
        left_d        = left_q;
        under_d       = under_q;
        barrier_d     = barrier_q;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    row_d = init_row;
                    col_d = init_column;
                    ori_d = init_orientation;
                end
                if (run) begin
                    state_d = S_RDF;
                end
            end
            S_RDF: state_d = S_RDL;
            S_RDL: begin
                front_data_d = mem_rdata;
                state_d      = S_RDU;
            end
            S_RDU: begin
                left_data_d = mem_rdata;
                state_d     = S_CAP;
            end
            S_CAP: begin
                head_d    = !front_ok || (front_data_q == CELL_WALL);
                left_d    = !left_ok || (left_data_q == CELL_WALL);
                under_d   = (mem_rdata == CELL_DIRT);
                barrier_d = front_ok && (front_data_q == CELL_TRASH);
                state_d   = S_TICK;
            end
            S_TICK: state_d = S_APPLY;
            S_APPLY: begin
                if (front) begin
                    if (!head_q) begin
                        row_d = fr_row;
                        col_d = fr_col;
                    end
                end else if (turn) begin
                    ori_d = turn_left(ori_q);
                end
                if (remove && barrier_q) begin
                    rm_cnt_d = rm_last ? '0 : rm_cnt_q + 1'b1;
                end else begin
                    rm_cnt_d = '0;
                end
                gap_cnt_d = GAP_W'(STEP_GAP - 1);
                state_d   = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = run ? S_RDF : S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        robot_clock_d = (state_d == S_TICK);
        step_done_d   = (state_d == S_APPLY);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            gap_cnt_q     <= '0;
            rm_cnt_q      <= '0;
            row_q         <= 6'd1;
            col_q         <= 6'd1;
            ori_q         <= OR_N;
            front_data_q  <= '0;
            left_data_q   <= '0;
            head_q        <= 1'b0;
            left_q        <= 1'b0;
            under_q       <= 1'b0;
            barrier_q     <= 1'b0;
            robot_clock_q <= 1'b0;
            step_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_cnt_q     <= gap_cnt_d;
            rm_cnt_q      <= rm_cnt_d;
            row_q         <= row_d;
            col_q         <= col_d;
            ori_q         <= ori_d;
            front_data_q  <= front_data_d;
            left_data_q   <= left_data_d;
            head_q        <= head_d;
            left_q        <= left_d;
            under_q       <= under_d;
            barrier_q     <= barrier_d;
            robot_clock_q <= robot_clock_d;
            step_done_q   <= step_done_d;
        end
    end

    // The write strobe is decoded in APPLY because remove is only valid in that cycle;
    // position is still pre-move there, so the front address is the cell being cleared.
    always_comb begin
        mem_addr = '0;
        case (state_q)
            S_RDF:   mem_addr = cell_addr(fr_row, fr_col);
            S_RDL:   mem_addr = cell_addr(lf_row, lf_col);
            S_RDU:   mem_addr = cell_addr(row_q, col_q);
            S_APPLY: mem_addr = cell_addr(fr_row, fr_col);
            default: mem_addr = '0;
        endcase
    end

    assign mem_we    = (state_q == S_APPLY) && remove && barrier_q && rm_last;
    assign mem_wdata = 3'd0;

    assign head              = head_q;
    assign left              = left_q;
    assign under             = under_q;
    assign barrier           = barrier_q;
    assign robot_clock       = robot_clock_q;
    assign step_done         = step_done_q;
    assign robot_row         = row_q;
    assign robot_column      = col_q;
    assign robot_orientation = ori_q;
    assign busy              = (state_q != S_IDLE);

endmodule

// File: tb/tb_world_step_sequencer.sv
// Bench for world_step_sequencer: map RAM model, directed steps, scoreboard of per-step results.
`timescale 1ns/1ps
module tb_world_step_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       load = 1'b0;
    logic [5:0] init_row = 6'd1;
    logic [5:0] init_column = 6'd1;
    logic [1:0] init_orientation = 2'd0;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [2:0] mem_wdata;
    logic [2:0] mem_rdata = 3'd0;
    logic       head, left, under, barrier, robot_clock;
    logic       front = 1'b0;
    logic       turn = 1'b0;
    logic       remove = 1'b0;
    logic [5:0] robot_row, robot_column;
    logic [1:0] robot_orientation;
    logic       busy, step_done;

    int checks = 0;
    int errors = 0;

    world_step_sequencer dut (
        .clock(clock), .reset(reset), .run(run), .load(load),
        .init_row(init_row), .init_column(init_column), .init_orientation(init_orientation),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .head(head), .left(left), .under(under), .barrier(barrier), .robot_clock(robot_clock),
        .front(front), .turn(turn), .remove(remove),
        .robot_row(robot_row), .robot_column(robot_column), .robot_orientation(robot_orientation),
        .busy(busy), .step_done(step_done)
    );

    always #5 clock = ~clock;

    // Map RAM with one-cycle read latency; the bench preloads cells through the poke port.
    logic [2:0] ram [0:255];
    logic       poke_en = 1'b0;
    logic [7:0] poke_addr = 8'd0;
    logic [2:0] poke_data = 3'd0;

    always @(posedge clock) begin
        if (poke_en) ram[poke_addr] <= poke_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic       h, l, u, b, we;
        logic [7:0] wa, af, al, au;
        logic [5:0] row, col;
        logic [1:0] ori;
        bit         per;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input logic h, l, u, b, we, input int wa, af, al, au,
                        input int row, col, ori, input bit per);
        exp_t e;
        e.h = h; e.l = l; e.u = u; e.b = b; e.we = we;
        e.wa = 8'(wa); e.af = 8'(af); e.al = 8'(al); e.au = 8'(au);
        e.row = 6'(row); e.col = 6'(col); e.ori = 2'(ori); e.per = per;
        exp_q.push_back(e);
    endtask

    // Monitor: every APPLY cycle pops one expected step and compares it.
    int         cyc = 0;
    int         last_done = 0;
    logic [7:0] hist [6];

    initial begin : monitor
        exp_t e;
        for (int i = 0; i < 6; i++) hist[i] = 8'd0;
        forever begin
            @(negedge clock);
            cyc++;
            for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = mem_addr;
            if (mem_we) begin
                chk("we_only_in_apply", int'(step_done), 1);
                chk("wdata", int'(mem_wdata), 0);
            end
            if (step_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_step", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("step at cycle %0d: pos (%0d,%0d,%0d) head=%0d left=%0d under=%0d barrier=%0d we=%0d",
                             cyc, robot_row, robot_column, robot_orientation, head, left, under, barrier, mem_we);
                    chk("addr_front", int'(hist[5]), int'(e.af));
                    chk("addr_left", int'(hist[4]), int'(e.al));
                    chk("addr_own", int'(hist[3]), int'(e.au));
                    chk("head", int'(head), int'(e.h));
                    chk("left", int'(left), int'(e.l));
                    chk("under", int'(under), int'(e.u));
                    chk("barrier", int'(barrier), int'(e.b));
                    chk("robot_clock_low", int'(robot_clock), 0);
                    chk("mem_we", int'(mem_we), int'(e.we));
                    if (e.we) chk("write_addr", int'(mem_addr), int'(e.wa));
                    if (e.per) chk("period", cyc - last_done, 10);
                    last_done = cyc;
                    @(posedge clock);
                    #1;
                    chk("row_after", int'(robot_row), int'(e.row));
                    chk("col_after", int'(robot_column), int'(e.col));
                    chk("ori_after", int'(robot_orientation), int'(e.ori));
                end
            end
        end
    end

    task automatic poke(input int a, input int d);
        poke_addr = 8'(a);
        poke_data = 3'(d);
        poke_en = 1'b1;
        @(negedge clock);
        poke_en = 1'b0;
    endtask

    task automatic do_load(input int r, input int c, input int o);
        init_row = 6'(r);
        init_column = 6'(c);
        init_orientation = 2'(o);
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        chk("load_row", int'(robot_row), r);
        chk("load_col", int'(robot_column), c);
        chk("load_ori", int'(robot_orientation), o);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!step_done && n < 40);
        if (!step_done) chk("step_done_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("return_to_idle", int'(busy), 0);
    endtask

    initial begin : stimulus
        int n;
        repeat (3) @(negedge clock);
        chk("rst_row", int'(robot_row), 1);
        chk("rst_col", int'(robot_column), 1);
        chk("rst_ori", int'(robot_orientation), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_robot_clock", int'(robot_clock), 0);
        chk("rst_step_done", int'(step_done), 0);
        chk("rst_sensors", int'({head, left, under, barrier}), 0);
        chk("rst_mem", int'({mem_we, mem_addr}), 0);
        reset = 1'b1;
        @(negedge clock);
        for (int a = 0; a < 256; a++) poke(a, 0);

        // Reset in the middle of TICK aborts the step.
        do_load(2, 2, 2);
        run = 1'b1;
        n = 0;
        while (!robot_clock && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("reach_tick", int'(robot_clock), 1);
        reset = 1'b0;
        run = 1'b0;
        #1;
        chk("abort_robot_clock", int'(robot_clock), 0);
        chk("abort_busy", int'(busy), 0);
        @(negedge clock);
        chk("abort_mem_we", int'(mem_we), 0);
        chk("abort_row", int'(robot_row), 1);
        chk("abort_col", int'(robot_column), 1);
        chk("abort_ori", int'(robot_orientation), 0);
        reset = 1'b1;
        @(negedge clock);

        // Corner (1,1,N): front and left out of range, forward blocked.
        do_load(1, 1, 0);
        front = 1'b1;
        push(1, 1, 0, 0, 0, 0, 1, 20, 21, 1, 1, 0, 0);
        push(1, 1, 0, 0, 0, 0, 1, 20, 21, 1, 1, 0, 1);
        push(1, 1, 0, 0, 0, 0, 1, 20, 21, 1, 1, 0, 1);
        run = 1'b1;
        repeat (3) wait_done();
        @(negedge clock);
        run = 1'b0;
        wait_idle();

        // Move east from (5,5): dirt under, wall on the left.
        poke(105, 7);
        poke(85, 1);
        poke(106, 0);
        do_load(5, 5, 2);
        push(0, 1, 1, 0, 0, 0, 106, 85, 105, 5, 6, 2, 0);
        run = 1'b1;
        wait_done();
        @(negedge clock);
        run = 1'b0;
        wait_idle();

        // Trash in front of (3,3,S): third consecutive remove clears it.
        poke(83, 2);
        do_load(3, 3, 1);
        front = 1'b0;
        remove = 1'b1;
        push(0, 0, 0, 1, 0, 0, 83, 64, 63, 3, 3, 1, 0);
        push(0, 0, 0, 1, 0, 0, 83, 64, 63, 3, 3, 1, 1);
        push(0, 0, 0, 1, 1, 83, 83, 64, 63, 3, 3, 1, 1);
        push(0, 0, 0, 0, 0, 0, 83, 64, 63, 3, 3, 1, 1);
        run = 1'b1;
        repeat (4) wait_done();
        @(negedge clock);
        run = 1'b0;
        remove = 1'b0;
        wait_idle();
        chk("trash_cleared", int'(ram[83]), 0);

        // Interrupted remove pattern 1,0,1,1 never writes.
        poke(83, 2);
        remove = 1'b1;
        push(0, 0, 0, 1, 0, 0, 83, 64, 63, 3, 3, 1, 0);
        push(0, 0, 0, 1, 0, 0, 83, 64, 63, 3, 3, 1, 1);
        push(0, 0, 0, 1, 0, 0, 83, 64, 63, 3, 3, 1, 1);
        push(0, 0, 0, 1, 0, 0, 83, 64, 63, 3, 3, 1, 1);
        run = 1'b1;
        wait_done();
        @(negedge clock);
        remove = 1'b0;
        wait_done();
        @(negedge clock);
        remove = 1'b1;
        repeat (2) wait_done();
        @(negedge clock);
        run = 1'b0;
        remove = 1'b0;
        wait_idle();
        chk("trash_kept", int'(ram[83]), 2);

        // Four left turns from N at (5,5).
        do_load(5, 5, 0);
        turn = 1'b1;
        push(1, 0, 1, 0, 0, 0, 85, 104, 105, 5, 5, 3, 0);
        push(0, 0, 1, 0, 0, 0, 104, 125, 105, 5, 5, 1, 1);
        push(0, 0, 1, 0, 0, 0, 125, 106, 105, 5, 5, 2, 1);
        push(0, 1, 1, 0, 0, 0, 106, 85, 105, 5, 5, 0, 1);
        run = 1'b1;
        repeat (4) wait_done();
        @(negedge clock);
        run = 1'b0;
        turn = 1'b0;
        wait_idle();

        // run dropped during RDL: the step still completes; load while busy is ignored.
        push(1, 0, 1, 0, 0, 0, 85, 104, 105, 5, 5, 0, 0);
        run = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("rdl_addr", int'(mem_addr), 104);
        run = 1'b0;
        wait_done();
        @(negedge clock);
        init_row = 6'd9;
        init_column = 6'd9;
        init_orientation = 2'd1;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        wait_idle();
        chk("busy_load_row", int'(robot_row), 5);
        chk("busy_load_col", int'(robot_column), 5);
        chk("busy_load_ori", int'(robot_orientation), 0);
        do_load(7, 8, 3);

        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
